// File: rtl/mw_sr_driver.sv
// Control stage ahead of the magnetron SR latch: synchronises and debounces the
// front-panel inputs, runs the cooking-session FSM and emits one-cycle set/reset pulses.

module mw_sr_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Level is accepted once sync2 has disagreed with filt for DEBOUNCE_CYCLES edges in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module mw_sr_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  input  logic       timer_zero,
  output logic       s,
  output logic       r,
  output logic [1:0] state,
  output logic       cooking
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COOK  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic filt_start, filt_start_d;
  logic filt_stop, filt_stop_d;
  logic door_sync1, door_sync2, door_d;
  logic start_evt, stop_evt, door_evt, start_ok;
  logic [1:0] state_nxt;
  logic s_nxt, r_nxt;

  mw_sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_start (
    .clk (clk),
    .rst (rst),
    .din (start),
    .filt(filt_start)
  );

  mw_sr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_stop (
    .clk (clk),
    .rst (rst),
    .din (stop),
    .filt(filt_stop)
  );

  // Door is a safety input: synchronised only, never debounced
  always_ff @(posedge clk) begin
    if (rst) begin
      door_sync1   <= 1'b0;
      door_sync2   <= 1'b0;
      door_d       <= 1'b0;
      filt_start_d <= 1'b0;
      filt_stop_d  <= 1'b0;
    end else begin
      door_sync1   <= door_open;
      door_sync2   <= door_sync1;
      door_d       <= door_sync2;
      filt_start_d <= filt_start;
      filt_stop_d  <= filt_stop;
    end
  end

  assign start_evt = filt_start & ~filt_start_d;
  assign stop_evt  = filt_stop & ~filt_stop_d;
  assign door_evt  = door_sync2 & ~door_d;
  assign start_ok  = start_evt & ~door_sync2 & ~timer_zero;

  always_comb begin
    state_nxt = state;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_COOK;
          s_nxt     = 1'b1;
        end
      end
      ST_COOK: begin
        if (door_sync2 || stop_evt) begin
          state_nxt = ST_PAUSE;
          r_nxt     = 1'b1;
        end else if (timer_zero) begin
          state_nxt = ST_DONE;
          r_nxt     = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_evt) begin
          state_nxt = ST_IDLE;
          r_nxt     = 1'b1;
        end else if (start_ok) begin
          state_nxt = ST_COOK;
          s_nxt     = 1'b1;
        end
      end
      ST_DONE: begin
        if (stop_evt || door_evt) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
    // Reset always wins so the latch never sees s and r together
    if (r_nxt) begin
      s_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      s       <= 1'b0;
      r       <= 1'b1;
      cooking <= 1'b0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      r       <= r_nxt;
      cooking <= (state_nxt == ST_COOK);
    end
  end

endmodule

// File: tb/tb_mw_sr_driver.sv
// Scoreboard bench for mw_sr_driver: a history-window reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.

module tb_mw_sr_driver;

  localparam int D = 4;
  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_COOK  = 2'd1;
  localparam logic [1:0] M_PAUSE = 2'd2;
  localparam logic [1:0] M_DONE  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_open = 1'b0;
  logic       timer_zero = 1'b0;
  logic       s, r, cooking;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  mw_sr_driver #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .timer_zero(timer_zero),
    .s         (s),
    .r         (r),
    .state     (state),
    .cooking   (cooking)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample histories (index 0 = sample at previous edge)
  bit hs[$], hp[$], hd[$];
  bit fs, fs_d, fp, fp_d;
  logic [1:0] mst;

  // A debounced level flips once the last D synchronised samples all disagree with it
  function automatic bit settled(input bit q[$], input bit filt);
    settled = 1'b1;
    for (int k = 1; k <= D; k++)
      if (q[k] == filt) settled = 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit sevt, pevt, dsync, devt, es, er;
    if (rst) begin
      hs.delete(); hp.delete(); hd.delete();
      for (int k = 0; k < D + 2; k++) begin
        hs.push_back(1'b0); hp.push_back(1'b0); hd.push_back(1'b0);
      end
      fs = 1'b0; fs_d = 1'b0; fp = 1'b0; fp_d = 1'b0;
      mst = M_IDLE;
      exp_q.push_back({1'b0, 1'b1, M_IDLE, 1'b0});
    end else begin
      sevt  = fs & ~fs_d;
      pevt  = fp & ~fp_d;
      dsync = hd[1];
      devt  = hd[1] & ~hd[2];
      fs_d = fs;
      fp_d = fp;
      if (settled(hs, fs)) fs = ~fs;
      if (settled(hp, fp)) fp = ~fp;
      hs.push_front(start);     void'(hs.pop_back());
      hp.push_front(stop);      void'(hp.pop_back());
      hd.push_front(door_open); void'(hd.pop_back());
      es = 1'b0;
      er = 1'b0;
      case (mst)
        M_IDLE:  if (sevt && !dsync && !timer_zero) begin mst = M_COOK; es = 1'b1; end
        M_COOK:  if (dsync || pevt) begin mst = M_PAUSE; er = 1'b1; end
                 else if (timer_zero) begin mst = M_DONE; er = 1'b1; end
        M_PAUSE: if (pevt) begin mst = M_IDLE; er = 1'b1; end
                 else if (sevt && !dsync && !timer_zero) begin mst = M_COOK; es = 1'b1; end
        default: if (pevt || devt) mst = M_IDLE;
      endcase
      exp_q.push_back({es, er, mst, (mst == M_COOK)});
    end
  end

  always @(negedge clk) begin : monitor
    logic [4:0] got, want;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      got  = {s, r, state, cooking};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs t=%0t s/r/state/cooking got %b required %b", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Edges from the current negedge until the chosen pulse shows; -1 on timeout
  task automatic measure(input bit want_s, input int max_edges, output int lat);
    lat = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(negedge clk);
      if (want_s ? s : r) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(ref logic btn, input int hold);
    btn = 1'b1;
    idle(hold);
    btn = 1'b0;
    idle(10);
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    idle(4);
    rst = 1'b0;
    idle(3);

    start = 1'b1;
    measure(1'b1, 20, lat);
    check("start_to_s_latency", lat, D + 3);
    idle(3);
    start = 1'b0;
    idle(10);
    check("cook_state", int'({state, cooking}), int'({M_COOK, 1'b1}));

    press(start, 3);
    press(stop, 3);
    check("glitch_state", int'(state), int'(M_COOK));

    door_open = 1'b1;
    measure(1'b0, 10, lat);
    check("door_to_r_latency", lat, 3);
    press(start, 8);
    check("pause_door_open", int'(state), int'(M_PAUSE));
    door_open = 1'b0;
    idle(5);
    start = 1'b1;
    measure(1'b1, 20, lat);
    check("resume_s_latency", lat, D + 3);
    idle(3);
    start = 1'b0;
    idle(10);

    // stop_evt and timer_zero land on the same edge
    stop = 1'b1;
    idle(D + 2);
    timer_zero = 1'b1;
    @(negedge clk);
    timer_zero = 1'b0;
    check("coincide_pulse", int'({s, r, state}), int'({1'b0, 1'b1, M_PAUSE}));
    idle(3);
    stop = 1'b0;
    idle(10);
    stop = 1'b1;
    measure(1'b0, 20, lat);
    check("stop_to_r_latency", lat, D + 3);
    check("stop_to_idle", int'(state), int'(M_IDLE));
    idle(3);
    stop = 1'b0;
    idle(10);

    press(start, 8);
    timer_zero = 1'b1;
    measure(1'b0, 5, lat);
    timer_zero = 1'b0;
    check("timer_to_r_latency", lat, 1);
    check("done_state", int'(state), int'(M_DONE));
    press(start, 8);
    check("done_ignores_start", int'(state), int'(M_DONE));
    door_open = 1'b1;
    idle(6);
    check("done_door_to_idle", int'(state), int'(M_IDLE));
    door_open = 1'b0;
    idle(5);
    press(start, 8);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_cook", int'({s, r, state}), int'({1'b0, 1'b1, M_IDLE}));
    rst = 1'b0;
    idle(5);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0) stop = ~stop;
      if ($urandom_range(0, 39) == 0) door_open = ~door_open;
      timer_zero = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    timer_zero = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mw_sr_driver.md
Name: mw_sr_driver

Overview:
- Control-path stage directly upstream of the magnetron SR latch (inputs s, r; output q) in the microwave controller.
- Conditions the raw start/stop button, door and timer inputs: two-flop synchronisation, then debounce.
- Runs the cooking-session state machine and emits single-cycle set/reset pulses that drive the latch.
- Guarantees s and r are never asserted together and that unsafe conditions always clear the latch.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles (after sync) before a button level is accepted; minimum 2
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  raw start button, active-high, asynchronous to clk
stop  input  1  raw stop/cancel button, active-high, asynchronous
door_open  input  1  raw door sensor, 1 = open, asynchronous
timer_zero  input  1  countdown timer reached zero, synchronous to clk
s  output  1  set pulse to magnetron latch
r  output  1  reset pulse/level to magnetron latch
state  output  2  FSM state: 0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
cooking  output  1  high while state == COOK

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, s=0, r=1, cooking=0.
  - Sync flops, filtered levels and counters clear to 0.
  - r=1 is held for every cycle rst is high, so the latch clears even when reset arrives mid-COOK.
  - r drops to 0 on the first edge with rst=0 unless the FSM asserts it.
- Synchronisers: start, stop and door_open each pass through two flops (sync1, sync2). A raw change is visible on sync2 after edge 2.
- Debounce (start and stop only), per channel:
  - Counter increments each edge where sync2 != filt; it clears when they are equal.
  - filt takes sync2 at the edge where counter == DEBOUNCE_CYCLES-1 and sync2 != filt still holds. The counter clears at that same edge.
  - Result: filt changes DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw level.
  - A pulse shorter than DEBOUNCE_CYCLES cycles on sync2 is ignored.
- Events:
  - start_evt = filt_start & ~filt_start_d.
  - stop_evt = filt_stop & ~filt_stop_d.
  - door_evt = sync2_door & ~door_d.
  - Each *_d is a one-edge delayed copy. door_open is NOT debounced (safety path).
- FSM: registered state; s and r are registered and decoded from the transition taken at the same edge.
  - IDLE:
    - start_evt & ~door_sync & ~timer_zero -> COOK, s=1.
    - start_evt otherwise -> stay, no pulse.
  - COOK:
    - door_sync=1 or stop_evt -> PAUSE, r=1.
    - else timer_zero -> DONE, r=1.
    - door/stop take priority over timer_zero.
  - PAUSE:
    - stop_evt -> IDLE, r=1.
    - else start_evt & ~door_sync & ~timer_zero -> COOK, s=1.
    - stop_evt has priority.
  - DONE:
    - stop_evt or door_evt -> IDLE, no pulse.
    - start_evt ignored.
- Pulses:
  - s and r are high for exactly one cycle per transition, except r during reset.
  - s=1 and r=1 in the same cycle is illegal and must not occur.
  - If set and reset conditions coincide, reset wins.
- Latency:
  - raw start high -> s high: DEBOUNCE_CYCLES+3 edges.
  - raw door_open high while in COOK -> r high: 3 edges.
  - timer_zero high in COOK -> r high: 1 edge.
- cooking = (state == COOK), registered with the state.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, then hold rst=1 for 3 cycles -> r=1, s=0, state=0 throughout. r=0 one edge after rst falls.
- Door closed, start high for 10 cycles -> s=1 for exactly one cycle, 7 edges after start first sampled. state=1, cooking=1. r stays 0.
- While in COOK, start glitch high for 3 cycles, then stop glitch of 3 cycles -> no s/r pulse; state stays 1.
- While in COOK, door_open raised -> r pulse 3 edges later; state=2. Raising start while the door is open -> no s. Close the door, then a valid start press -> s pulse; state=1.
- While in COOK, timer_zero and a debounced stop_evt on the same edge -> a single r pulse; state=2 (PAUSE), not DONE. Then stop press -> r pulse; state=0.
- While in COOK, timer_zero=1 -> r next edge, state=3. Start press -> no change. Open door -> state=0, no pulse. Assert rst mid-COOK -> r=1 immediately at that edge, state=0.
